// File: rtl/tick_seq_pkg.sv
// -----------------------------------------------------------------------------
// tick_seq_pkg
// Shared definitions for the tick sequencer slice:
//   - default parameter values (FIFO depth, step width, count width)
//   - sequencer state enum (IDLE, ISSUE)
//   - request struct {step, count} at the default widths
// No ports; imported by tick_seq_fifo and tick_sequencer.
// -----------------------------------------------------------------------------
package tick_seq_pkg;

    localparam int unsigned DEF_FIFO_DEPTH  = 4;
    localparam int unsigned DEF_STEP_WIDTH  = 8;
    localparam int unsigned DEF_COUNT_WIDTH = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_t;

    typedef struct packed {
        logic [DEF_STEP_WIDTH-1:0]  step;
        logic [DEF_COUNT_WIDTH-1:0] count;
    } req_t;

endpackage

// File: rtl/tick_seq_fifo.sv
// -----------------------------------------------------------------------------
// tick_seq_fifo
// Synchronous request FIFO with asynchronous active-high reset.
// Storage type is a type parameter so the top can pass a request struct sized
// to its own STEP_WIDTH/COUNT_WIDTH.
// Parameters:
//   DEPTH  entries, power of two, >= 2
//   T      entry type (defaults to tick_seq_pkg::req_t)
// Ports:
//   clock      in   clock, all state on posedge
//   reset      in   asynchronous, active-high; empties the FIFO
//   push       in   write push_data (ignored while full, even if popping)
//   push_data  in   entry to write
//   pop        in   drop the head entry (ignored while empty)
//   head       out  current head entry (valid when !empty)
//   full       out  DEPTH entries stored
//   empty      out  no entries stored
// -----------------------------------------------------------------------------
module tick_seq_fifo
    import tick_seq_pkg::*;
#(
    parameter int unsigned DEPTH = DEF_FIFO_DEPTH,
    parameter type         T     = req_t
) (
    input  logic clock,
    input  logic reset,
    input  logic push,
    input  T     push_data,
    input  logic pop,
    output T     head,
    output logic full,
    output logic empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    T             mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic         do_push;
    logic         do_pop;

    // Pointers carry one extra wrap bit: equal low bits with differing wrap
    // bits means full, fully equal pointers mean empty.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign head = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Storage needs no reset: entries are only read between push and pop.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/tick_sequencer.sv
// -----------------------------------------------------------------------------
// tick_sequencer
// Buffers (step, count) requests and replays each one as `count` single-cycle
// tick strobes carrying `step`, feeding an 8-bit step accumulator. Requests
// with count 0 retire without ticks. A downstream stall holds the current
// tick; no tick is ever dropped.
// Optional feature macro: TICK_SEQUENCER_STATS_EN adds issued_total, a 16-bit
// wrapping count of cycles with tick_valid high.
// Parameters:
//   FIFO_DEPTH   request buffer entries (power of two, >= 2)
//   STEP_WIDTH   width of step value
//   COUNT_WIDTH  width of per-request tick count
// Ports:
//   clock         in   clock, all state on posedge
//   reset         in   asynchronous, active-high; clears all state at once
//   req_valid     in   request offered
//   req_ready     out  request accepted when req_valid && req_ready
//   req_step      in   value added per tick
//   req_count     in   number of ticks (0 legal)
//   tick_stall    in   downstream hold; no tick while high
//   tick_valid    out  tick strobe
//   tick_step     out  step of the current request
//   busy          out  FIFO non-empty or FSM not IDLE
//   done          out  one-cycle pulse the cycle after a request retires
//   issued_total  out  (macro only) ticks issued since reset, wraps
// -----------------------------------------------------------------------------
module tick_sequencer
    import tick_seq_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH  = DEF_FIFO_DEPTH,
    parameter int unsigned STEP_WIDTH  = DEF_STEP_WIDTH,
    parameter int unsigned COUNT_WIDTH = DEF_COUNT_WIDTH
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [STEP_WIDTH-1:0]  req_step,
    input  logic [COUNT_WIDTH-1:0] req_count,
    input  logic                   tick_stall,
    output logic                   tick_valid,
    output logic [STEP_WIDTH-1:0]  tick_step,
    output logic                   busy,
    output logic                   done
`ifdef TICK_SEQUENCER_STATS_EN
    ,
    output logic [15:0]            issued_total
`endif
);

    typedef struct packed {
        logic [STEP_WIDTH-1:0]  step;
        logic [COUNT_WIDTH-1:0] count;
    } entry_t;

    entry_t                 req_in;
    entry_t                 fifo_head;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   fifo_push;
    logic                   fifo_pop;

    state_t                 state_q;
    state_t                 state_d;
    logic [STEP_WIDTH-1:0]  cur_step_q;
    logic [COUNT_WIDTH-1:0] cur_left_q;
    logic                   done_q;
    logic                   done_d;
    logic                   load;

    assign req_in    = {req_step, req_count};
    // Held low while reset is asserted, then follows FIFO occupancy.
    assign req_ready = !reset && !fifo_full;
    assign fifo_push = req_valid && req_ready;

    tick_seq_fifo #(
        .DEPTH (FIFO_DEPTH),
        .T     (entry_t)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (req_in),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Next-state / strobe logic. A pop in IDLE loads the head into cur_*;
    // a zero-count request retires immediately and stays in IDLE.
    always_comb begin
        state_d    = state_q;
        fifo_pop   = 1'b0;
        load       = 1'b0;
        tick_valid = 1'b0;
        done_d     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    load     = 1'b1;
                    if (fifo_head.count != '0) begin
                        state_d = ISSUE;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            ISSUE: begin
                tick_valid = !tick_stall;
                if (!tick_stall && (cur_left_q == COUNT_WIDTH'(1))) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cur_step_q <= '0;
            cur_left_q <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            if (load) begin
                cur_step_q <= fifo_head.step;
                cur_left_q <= fifo_head.count;
            end else if (tick_valid) begin
                cur_left_q <= cur_left_q - COUNT_WIDTH'(1);
            end
        end
    end

    assign tick_step = cur_step_q;
    assign done      = done_q;
    assign busy      = !fifo_empty || (state_q != IDLE);

`ifdef TICK_SEQUENCER_STATS_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            issued_total <= '0;
        end else if (tick_valid) begin
            issued_total <= issued_total + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_tick_sequencer.sv
module tb_tick_sequencer;

    logic       clock;
    logic       reset;
    logic       req_valid;
    logic       req_ready;
    logic [7:0] req_step;
    logic [3:0] req_count;
    logic       tick_stall;
    logic       tick_valid;
    logic [7:0] tick_step;
    logic       busy;
    logic       done;
`ifdef TICK_SEQUENCER_STATS_EN
    logic [15:0] issued_total;
`endif

    int pass_cnt  = 0;
    int total_cnt = 0;

    // Scoreboard: expected tick steps and outstanding done pulses
    logic [7:0] exp_step[$];
    int         pending_done = 0;

    int         cyc = 0;
    int         ticks_total = 0;
    int         done_total = 0;
    int         acc = 0;
    int         tick_cyc[$];
    int         done_cyc[$];

    tick_sequencer #(
        .FIFO_DEPTH  (4),
        .STEP_WIDTH  (8),
        .COUNT_WIDTH (4)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_step     (req_step),
        .req_count    (req_count),
        .tick_stall   (tick_stall),
        .tick_valid   (tick_valid),
        .tick_step    (tick_step),
        .busy         (busy),
        .done         (done)
`ifdef TICK_SEQUENCER_STATS_EN
        ,
        .issued_total (issued_total)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Output monitor: pops the scoreboard on every tick and done pulse
    always @(negedge clock) begin
        if (!reset) begin
            if (tick_valid) begin
                ticks_total++;
                tick_cyc.push_back(cyc);
                acc = (acc + int'(tick_step)) & 8'hFF;
                total_cnt++;
                if (exp_step.size() == 0) begin
                    $display("FAIL unexpected_tick: got tick step=%0d at cycle %0d, expected no tick", tick_step, cyc);
                end else begin
                    logic [7:0] e;
                    e = exp_step.pop_front();
                    if (tick_step !== e) $display("FAIL tick_step: got %0d, expected %0d", tick_step, e);
                    else pass_cnt++;
                end
            end
            if (tick_stall) begin
                total_cnt++;
                if (tick_valid !== 1'b0) $display("FAIL stall_tick: tick_valid=%b during stall, expected 0", tick_valid);
                else pass_cnt++;
            end
            if (done) begin
                done_total++;
                done_cyc.push_back(cyc);
                total_cnt++;
                if (pending_done <= 0) begin
                    $display("FAIL unexpected_done: done=1 at cycle %0d, expected no pending request", cyc);
                end else begin
                    pending_done--;
                    pass_cnt++;
                end
            end
        end
    end

    task automatic send(input logic [7:0] s, input logic [3:0] c, output int waited);
        bit ok;
        ok = 0;
        waited = 0;
        req_valid = 1'b1;
        req_step  = s;
        req_count = c;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (req_ready) begin
                ok = 1;
                break;
            end
            waited++;
        end
        if (ok) begin
            for (int k = 0; k < int'(c); k++) exp_step.push_back(s);
            pending_done++;
            @(posedge clock);
            #1;
        end else begin
            total_cnt++;
            $display("FAIL accept_timeout: req_ready stayed 0 for step=%0d count=%0d, expected acceptance", s, c);
        end
        req_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        bit ok;
        ok = 0;
        for (int i = 0; i < 400; i++) begin
            @(posedge clock);
            #1;
            if (!busy && exp_step.size() == 0 && pending_done == 0) begin
                ok = 1;
                break;
            end
        end
        total_cnt++;
        if (!ok) $display("FAIL %s_idle: busy=%b pending_ticks=%0d pending_done=%0d, expected all 0", name, busy, exp_step.size(), pending_done);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req_valid = 1'b0;
        req_step = '0;
        req_count = '0;
        tick_stall = 1'b0;
        #2;
        total_cnt++;
        if ({req_ready, tick_valid, tick_step, busy, done} !== 12'h000)
            $display("FAIL reset_values: ready=%b valid=%b step=%0d busy=%b done=%b, expected all 0",
                     req_ready, tick_valid, tick_step, busy, done);
        else pass_cnt++;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        #1;
        total_cnt++;
        if (req_ready !== 1'b1) $display("FAIL ready_after_reset: req_ready=%b, expected 1", req_ready);
        else pass_cnt++;
        acc = 0;
    endtask

    task automatic test_single();
        int w, n, a0;
        tick_cyc.delete();
        done_cyc.delete();
        a0 = acc;
        send(8'd3, 4'd2, w);
        n = cyc - 1;
        wait_idle("single");
        total_cnt++;
        if (tick_cyc.size() != 2 || tick_cyc[0] != n + 2 || tick_cyc[1] != n + 3)
            $display("FAIL single_tick_timing: %0d ticks, first at N+%0d, expected 2 ticks at N+2,N+3",
                     tick_cyc.size(), tick_cyc.size() > 0 ? tick_cyc[0] - n : -1);
        else pass_cnt++;
        total_cnt++;
        if (done_cyc.size() != 1 || done_cyc[0] != n + 4)
            $display("FAIL single_done_timing: %0d done pulses, first at N+%0d, expected 1 at N+4",
                     done_cyc.size(), done_cyc.size() > 0 ? done_cyc[0] - n : -1);
        else pass_cnt++;
        total_cnt++;
        if (((acc - a0) & 8'hFF) != 6) $display("FAIL single_acc: accumulator added %0d, expected 6", (acc - a0) & 8'hFF);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int w, d0;
        bit gaps_ok;
        tick_cyc.delete();
        d0 = done_total;
        tick_stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            send(8'(10 + i), 4'd1, w);
            total_cnt++;
            if (w != 0) $display("FAIL b2b_accept_%0d: waited %0d cycles, expected 0", i, w);
            else pass_cnt++;
        end
        req_valid = 1'b1;
        req_step  = 8'd15;
        req_count = 4'd1;
        @(negedge clock);
        total_cnt++;
        if (req_ready !== 1'b0) $display("FAIL b2b_full: req_ready=%b with FIFO full, expected 0", req_ready);
        else pass_cnt++;
        @(posedge clock);
        #1;
        tick_stall = 1'b0;
        // Full through the pop cycle, ready again the cycle after
        send(8'd15, 4'd1, w);
        total_cnt++;
        if (w != 2) $display("FAIL b2b_full_pop: 6th request waited %0d cycles, expected 2", w);
        else pass_cnt++;
        wait_idle("b2b");
        total_cnt++;
        if (done_total - d0 != 6) $display("FAIL b2b_done_count: %0d done pulses, expected 6", done_total - d0);
        else pass_cnt++;
        gaps_ok = (tick_cyc.size() == 6);
        for (int i = 1; i < tick_cyc.size(); i++) if (tick_cyc[i] - tick_cyc[i-1] != 2) gaps_ok = 0;
        total_cnt++;
        if (!gaps_ok) $display("FAIL b2b_spacing: %0d ticks with gaps not all 2 cycles, expected 6 ticks spaced 2", tick_cyc.size());
        else pass_cnt++;
    endtask

    task automatic test_stall();
        int w, t0, d0;
        bit seen;
        t0 = ticks_total;
        d0 = done_total;
        send(8'd7, 4'd3, w);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (tick_valid) begin
                seen = 1;
                break;
            end
        end
        total_cnt++;
        if (!seen) $display("FAIL stall_first_tick: tick_valid=0 for 20 cycles, expected a tick");
        else pass_cnt++;
        @(posedge clock);
        #1;
        tick_stall = 1'b1;
        repeat (2) begin
            @(negedge clock);
            total_cnt++;
            if (busy !== 1'b1) $display("FAIL stall_busy: busy=%b while stalled, expected 1", busy);
            else pass_cnt++;
            @(posedge clock);
            #1;
        end
        tick_stall = 1'b0;
        wait_idle("stall");
        total_cnt++;
        if (ticks_total - t0 != 3 || done_total - d0 != 1)
            $display("FAIL stall_counts: %0d ticks %0d done, expected 3 ticks 1 done", ticks_total - t0, done_total - d0);
        else pass_cnt++;
    endtask

    task automatic test_zero_count();
        int w, t0, d0;
        bit seen;
        t0 = ticks_total;
        d0 = done_total;
        send(8'd9, 4'd0, w);
        send(8'd1, 4'd1, w);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clock);
            #1;
            if (done_total != d0) begin
                seen = 1;
                break;
            end
        end
        total_cnt++;
        if (!seen || ticks_total != t0)
            $display("FAIL zero_count_done: done_seen=%0d ticks=%0d before first done, expected 1 and 0", seen, ticks_total - t0);
        else pass_cnt++;
        wait_idle("zero");
        total_cnt++;
        if (ticks_total - t0 != 1 || done_total - d0 != 2)
            $display("FAIL zero_count_totals: %0d ticks %0d done, expected 1 tick 2 done", ticks_total - t0, done_total - d0);
        else pass_cnt++;
    endtask

    task automatic test_mid_reset();
        int w, t0;
        bit seen;
        send(8'd9, 4'd4, w);
        send(8'd4, 4'd2, w);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (tick_valid) begin
                seen = 1;
                break;
            end
        end
        @(posedge clock);
        @(negedge clock);
        @(posedge clock);
        #3;
        // Two ticks issued, two left, second request still buffered
        reset = 1'b1;
        exp_step.delete();
        pending_done = 0;
        #1;
        total_cnt++;
        if (!seen || {tick_valid, busy, done, req_ready} !== 4'b0000 || tick_step !== 8'd0)
            $display("FAIL mid_reset: seen=%0d valid=%b busy=%b done=%b ready=%b step=%0d, expected ticks seen and all 0",
                     seen, tick_valid, busy, done, req_ready, tick_step);
        else pass_cnt++;
        @(posedge clock);
        #1;
        reset = 1'b0;
        t0 = ticks_total;
        repeat (10) @(posedge clock);
        #1;
        total_cnt++;
        if (ticks_total != t0 || busy !== 1'b0)
            $display("FAIL post_reset_quiet: %0d ticks busy=%b, expected 0 ticks busy=0", ticks_total - t0, busy);
        else pass_cnt++;
        send(8'd2, 4'd1, w);
        wait_idle("post_reset");
        total_cnt++;
        if (ticks_total - t0 != 1) $display("FAIL post_reset_new: %0d ticks, expected 1", ticks_total - t0);
        else pass_cnt++;
    endtask

`ifdef TICK_SEQUENCER_STATS_EN
    task automatic test_stats();
        int w, t0;
        @(posedge clock);
        #1;
        reset = 1'b1;
        #1;
        total_cnt++;
        if (issued_total !== 16'd0) $display("FAIL stats_reset: issued_total=%0d, expected 0", issued_total);
        else pass_cnt++;
        @(posedge clock);
        #1;
        reset = 1'b0;
        t0 = ticks_total;
        for (int i = 0; i < 3; i++) send(8'd1, 4'd15, w);
        wait_idle("stats");
        total_cnt++;
        if (issued_total !== 16'd45 || ticks_total - t0 != 45)
            $display("FAIL stats_total: issued_total=%0d observed=%0d, expected 45", issued_total, ticks_total - t0);
        else pass_cnt++;
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
        test_zero_count();
        test_mid_reset();
`ifdef TICK_SEQUENCER_STATS_EN
        test_stats();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
